// File: rtl/vga_frame_output_core_pkg.sv
// Shared types and constants for the VGA frame output core: pixel record,
// FIFO entry, FSM states and default 640x480 timing.
package vga_frame_output_core_pkg;
   localparam int R_SIZE   = 8;
   localparam int G_SIZE   = 8;
   localparam int B_SIZE   = 8;
   localparam int RGB_SIZE = R_SIZE + G_SIZE + B_SIZE;
   localparam int POS_W    = 12;

   localparam int DEF_H_DISPLAY = 640;
   localparam int DEF_H_FP      = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BP      = 48;
   localparam int DEF_V_DISPLAY = 480;
   localparam int DEF_V_FP      = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BP      = 33;
   localparam int DEF_PIX_DIV   = 2;
   localparam int DEF_FIFO_DEPTH   = 16;
   localparam int DEF_AFULL_MARGIN = 4;

   typedef struct packed {
      logic [POS_W-1:0]  hc;
      logic [POS_W-1:0]  vc;
      logic              start;
      logic [R_SIZE-1:0] r;
      logic [G_SIZE-1:0] g;
      logic [B_SIZE-1:0] b;
   } vga_frame_t;

   typedef struct packed {
      logic              start;
      logic [R_SIZE-1:0] r;
      logic [G_SIZE-1:0] g;
      logic [B_SIZE-1:0] b;
   } fifo_entry_t;

   typedef enum logic [1:0] {SEEK, ARMED, RUN} vga_state_e;

   function automatic logic in_window(input int cnt, input int lo, input int hi);
      return (cnt >= lo) && (cnt < hi);
   endfunction
endpackage

// File: rtl/vga_frame_output_core_if.sv
// Upstream pixel stream: valid + pixel record forward, stall backward.
interface vga_frame_output_core_if;
   import vga_frame_output_core_pkg::*;
   logic       source_vld;
   vga_frame_t source_frame;
   logic       stall;

   modport master (output source_vld, output source_frame, input stall);
   modport slave  (input source_vld, input source_frame, output stall);
endinterface

// File: rtl/vga_sync_fifo.sv
// Single-clock show-ahead FIFO; head is valid whenever empty is low.
module vga_sync_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [DW-1:0]          wdata,
   input  logic                   pop,
   output logic [DW-1:0]          head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Storage needs no reset: empty gates every use of head.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/vga_frame_output_core.sv
// VGA raster timing plus a pixel FIFO that aligns the upstream stream to the
// raster origin via the start flag and drops to black on loss of sync.
module vga_frame_output_core
   import vga_frame_output_core_pkg::*;
#(
   parameter int H_DISPLAY    = DEF_H_DISPLAY,
   parameter int H_FP         = DEF_H_FP,
   parameter int H_SYNC       = DEF_H_SYNC,
   parameter int H_BP         = DEF_H_BP,
   parameter int V_DISPLAY    = DEF_V_DISPLAY,
   parameter int V_FP         = DEF_V_FP,
   parameter int V_SYNC       = DEF_V_SYNC,
   parameter int V_BP         = DEF_V_BP,
   parameter int PIX_DIV      = DEF_PIX_DIV,
   parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
   parameter int AFULL_MARGIN = DEF_AFULL_MARGIN
) (
   input  logic                    clk,
   input  logic                    rst_n,
   vga_frame_output_core_if.slave  src,
   output logic                    vga_hsync,
   output logic                    vga_vsync,
   output logic [R_SIZE-1:0]       vga_r,
   output logic [G_SIZE-1:0]       vga_g,
   output logic [B_SIZE-1:0]       vga_b,
   output logic                    underflow
);
   localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam int CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] STALL_AT = CW'(FIFO_DEPTH - AFULL_MARGIN);

   logic [DIV_W-1:0] div_cnt;
   logic [HW-1:0]    h_cnt;
   logic [VW-1:0]    v_cnt;
   logic             tick, active, at_origin;

   assign tick      = (div_cnt == '0);
   assign active    = (h_cnt < HW'(H_DISPLAY)) && (v_cnt < VW'(V_DISPLAY));
   assign at_origin = (h_cnt == '0) && (v_cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         h_cnt   <= '0;
         v_cnt   <= '0;
      end else begin
         div_cnt <= (div_cnt == DIV_W'(PIX_DIV - 1)) ? '0 : div_cnt + 1'b1;
         if (tick) begin
            if (h_cnt == HW'(H_TOTAL - 1)) begin
               h_cnt <= '0;
               v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
            end else begin
               h_cnt <= h_cnt + 1'b1;
            end
         end
      end
   end

   fifo_entry_t   wr_entry, head;
   logic [CW-1:0] fifo_count;
   logic          fifo_empty, fifo_full, push, pop, stall;
   logic          pos_unused;

   // Raster position from upstream is not stored; alignment comes from start.
   assign pos_unused = ^{src.source_frame.hc, src.source_frame.vc};
   assign wr_entry   = '{start: src.source_frame.start, r: src.source_frame.r,
                         g: src.source_frame.g, b: src.source_frame.b};
   assign stall      = rst_n & (fifo_count >= STALL_AT);
   assign src.stall  = stall;
   assign push       = src.source_vld & ~stall & ~fifo_full;

   vga_sync_fifo #(.DW($bits(fifo_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (wr_entry),
      .pop   (pop),
      .head  (head),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   vga_state_e              state, state_nx;
   logic [RGB_SIZE-1:0]     pix_nx;
   logic                    uf_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= SEEK;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      pix_nx   = '0;
      uf_nx    = 1'b0;
      unique case (state)
         SEEK: begin
            // Flush stale pixels at full clk rate until a frame start shows up.
            if (!fifo_empty) begin
               if (head.start) state_nx = ARMED;
               else            pop      = 1'b1;
            end
         end
         ARMED: begin
            if (tick && at_origin) begin
               pop      = 1'b1;
               pix_nx   = {head.r, head.g, head.b};
               state_nx = RUN;
            end
         end
         RUN: begin
            if (tick && active) begin
               if (fifo_empty || (head.start && !at_origin)) begin
                  uf_nx    = 1'b1;
                  state_nx = SEEK;
               end else begin
                  pop    = 1'b1;
                  pix_nx = {head.r, head.g, head.b};
               end
            end
         end
         default: state_nx = SEEK;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_hsync <= 1'b1;
         vga_vsync <= 1'b1;
         {vga_r, vga_g, vga_b} <= '0;
         underflow <= 1'b0;
      end else begin
         underflow <= uf_nx;
         if (tick) begin
            vga_hsync <= ~in_window(int'(h_cnt), H_DISPLAY + H_FP, H_DISPLAY + H_FP + H_SYNC);
            vga_vsync <= ~in_window(int'(v_cnt), V_DISPLAY + V_FP, V_DISPLAY + V_FP + V_SYNC);
            {vga_r, vga_g, vga_b} <= pix_nx;
         end
      end
   end
endmodule

// File: tb/tb_vga_frame_output_core.sv
// Directed bench for vga_frame_output_core on a 12x7 raster: a raster monitor
// checks sync/colour per pixel against a queue of expected active pixels.
module tb_vga_frame_output_core;
   import vga_frame_output_core_pkg::*;

   localparam int HT = 12;
   localparam int VT = 7;
   localparam int FRAME_PIX = HT * VT;
   localparam int FRAME_CLK = FRAME_PIX * 2;

   logic clk = 1'b0;
   logic rst_n;
   logic vga_hsync, vga_vsync, underflow;
   logic [R_SIZE-1:0] vga_r;
   logic [G_SIZE-1:0] vga_g;
   logic [B_SIZE-1:0] vga_b;

   vga_frame_output_core_if src_if();

   vga_frame_output_core #(
      .H_DISPLAY(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_DISPLAY(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .PIX_DIV(2), .FIFO_DEPTH(8), .AFULL_MARGIN(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .src(src_if),
      .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0, m_chk = 0, m_fail = 0;
   int n_pe;
   int stall_rises = 0;
   logic stall_q = 1'b0;
   logic [RGB_SIZE-1:0] exp_q[$];
   int uf_log[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mchk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      m_chk++;
      assert (obs === exp) else begin
         m_fail++;
         $error("FAIL %s @pe%0d: observed %0h expected %0h", tag, n_pe, obs, exp);
      end
   endtask

   // Posedges since reset release; odd posedges carry pixel ticks.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) n_pe <= 0;
      else        n_pe <= n_pe + 1;
   end

   always @(negedge clk) begin
      int p, f, h, v;
      logic [RGB_SIZE-1:0] e;
      int cnt;
      if (rst_n && n_pe > 0) begin
         cnt = int'(dut.u_fifo.count);
         if (n_pe % 2 == 1) begin
            p = ((n_pe - 1) / 2) % FRAME_PIX;
            f = ((n_pe - 1) / 2) / FRAME_PIX;
            h = p % HT;
            v = p / HT;
            mchk("hsync", 32'(vga_hsync), 32'(!(h >= 9 && h < 11)));
            mchk("vsync", 32'(vga_vsync), 32'(v != 5));
            e = '0;
            if (h < 8 && v < 4 && exp_q.size() > 0) e = exp_q.pop_front();
            mchk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e));
            if (underflow) uf_log.push_back(f * 1000 + p);
         end else begin
            mchk("underflow_width", 32'(underflow), 32'd0);
         end
         mchk("stall_thresh", 32'(src_if.stall), 32'(cnt >= 6));
         mchk("fifo_max", 32'(cnt <= 8), 32'd1);
         if (src_if.stall && !stall_q) begin
            stall_rises++;
            mchk("stall_rise_cnt", 32'(cnt), 32'd6);
         end
         stall_q = src_if.stall;
      end
   end

   task automatic push_px(input logic st, input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b, input int idx);
      int w = 0;
      src_if.source_vld   = 1'b1;
      src_if.source_frame = '{hc: 12'(idx % 8), vc: 12'(idx / 8), start: st, r: r, g: g, b: b};
      while (src_if.stall && w < 2000) begin
         @(negedge clk);
         w++;
      end
      chk("push_timeout", 32'(w < 2000), 32'd1);
      @(negedge clk);
      src_if.source_vld = 1'b0;
   endtask

   task automatic push_frame(input int id, input int npix);
      logic [7:0] r, g, b;
      for (int i = 0; i < npix; i++) begin
         r = 8'(i);
         g = 8'(id);
         b = 8'(i) ^ 8'h5A;
         exp_q.push_back({r, g, b});
         push_px(i == 0, r, g, b, i);
      end
   endtask

   task automatic release_reset();
      exp_q.delete();
      uf_log.delete();
      // Nothing can be armed before the first origin, so frame 0 is black.
      for (int i = 0; i < 32; i++) exp_q.push_back('0);
      rst_n = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      src_if.source_vld = 1'b0;
      repeat (3) @(negedge clk);
      release_reset();
   endtask

   task automatic wait_pe(input int target);
      int g = 0;
      while (n_pe < target && g < 100000) begin
         @(negedge clk);
         g++;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, rises0;
      rst_n = 1'b0;
      src_if.source_vld   = 1'b0;
      src_if.source_frame = '0;
      repeat (2) @(negedge clk);
      chk("rst_hsync", 32'(vga_hsync), 32'd1);
      chk("rst_vsync", 32'(vga_vsync), 32'd1);
      chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
      chk("rst_underflow", 32'(underflow), 32'd0);
      chk("rst_stall", 32'(src_if.stall), 32'd0);
      chk("rst_fifo_empty", 32'(dut.u_fifo.empty), 32'd1);
      chk("rst_state", 32'(dut.state), 32'(SEEK));
      chk("rst_hcnt", 32'(dut.h_cnt), 32'd0);

      // Idle raster: sync only, black, no underflow.
      do_reset();
      wait_pe(2 * FRAME_CLK);
      chk("idle_no_uf", 32'(uf_log.size()), 32'd0);
      chk("idle_exp_drained", 32'(exp_q.size()), 32'd0);

      // Two back-to-back frames, upstream always valid.
      do_reset();
      rises0 = stall_rises;
      push_frame(1, 32);
      push_frame(2, 32);
      wait_pe(3 * FRAME_CLK);
      chk("stream_no_uf", 32'(uf_log.size()), 32'd0);
      chk("stream_all_shown", 32'(exp_q.size()), 32'd0);
      chk("stream_stall_rose", 32'(stall_rises > rises0), 32'd1);

      // Garbage ahead of the first frame start is discarded.
      do_reset();
      for (int i = 0; i < 3; i++) push_px(1'b0, 8'hEE, 8'hEE, 8'hEE, i);
      push_frame(1, 32);
      wait_pe(2 * FRAME_CLK);
      chk("garbage_no_uf", 32'(uf_log.size()), 32'd0);
      chk("garbage_all_shown", 32'(exp_q.size()), 32'd0);

      // Frame 2 truncated after 10 pixels, then a fresh aligned frame.
      do_reset();
      push_frame(1, 32);
      push_frame(2, 10);
      for (int i = 0; i < 22; i++) exp_q.push_back('0);
      w = 0;
      while (uf_log.size() == 0 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      chk("uf_seen", 32'(uf_log.size() > 0), 32'd1);
      push_frame(3, 32);
      wait_pe(4 * FRAME_CLK);
      chk("uf_count", 32'(uf_log.size()), 32'd1);
      chk("uf_position", 32'(uf_log.size() > 0 ? uf_log[0] : -1), 32'(2 * 1000 + 14));
      chk("uf_all_shown", 32'(exp_q.size()), 32'd0);

      // Asynchronous reset mid-frame with a loaded FIFO.
      do_reset();
      push_frame(1, 32);
      chk("pre_rst_loaded", 32'(dut.u_fifo.empty), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_hsync", 32'(vga_hsync), 32'd1);
      chk("mid_rst_vsync", 32'(vga_vsync), 32'd1);
      chk("mid_rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
      chk("mid_rst_underflow", 32'(underflow), 32'd0);
      chk("mid_rst_stall", 32'(src_if.stall), 32'd0);
      chk("mid_rst_fifo_cnt", 32'(dut.u_fifo.count), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      release_reset();
      chk("post_rst_empty", 32'(dut.u_fifo.empty), 32'd1);
      push_frame(1, 32);
      wait_pe(2 * FRAME_CLK);
      chk("post_rst_no_uf", 32'(uf_log.size()), 32'd0);
      chk("post_rst_all_shown", 32'(exp_q.size()), 32'd0);

      n_chk  += m_chk;
      n_fail += m_fail;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/vga_frame_output_core.md
VGA_FRAME_OUTPUT_CORE -- requirements
Module: vga_frame_output_core

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_DISPLAY 640: active pixels per line.
- H_FP 16: horizontal front porch.
- H_SYNC 96: hsync width.
- H_BP 48: horizontal back porch.
- V_DISPLAY 480: active lines.
- V_FP 10: vertical front porch.
- V_SYNC 2: vsync width.
- V_BP 33: vertical back porch.
- PIX_DIV 2: clk cycles per pixel tick.
- FIFO_DEPTH 16: pixel FIFO entries, power of two.
- AFULL_MARGIN 4: free entries left when stall asserts.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk in 1: the single clock; every register is clocked by it.
- rst_n in 1: reset, asynchronous assert, active-low.
- source_vld in 1: upstream pixel valid.
- source_frame in vga_frame_t: pixel record (hc, vc, start, r, g, b).
- stall out 1: back-pressure to the upstream pipeline.
- vga_hsync out 1: horizontal sync, active-low.
- vga_vsync out 1: vertical sync, active-low.
- vga_r out R_SIZE, vga_g out G_SIZE, vga_b out B_SIZE: pixel colour.
- underflow out 1: one-cycle pulse on loss of pixel sync.

Function
REQ-003 A pixel tick SHALL fire once every PIX_DIV clk cycles; a divider counter runs 0..PIX_DIV-1 and fires the tick at 0.
REQ-004 h_cnt SHALL count 0..H_TOTAL-1 on ticks, where H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP. v_cnt SHALL count 0..V_TOTAL-1, incrementing when h_cnt wraps. Both counters SHALL wrap to 0.
REQ-005 active = h_cnt<H_DISPLAY and v_cnt<V_DISPLAY.
REQ-006 Sync timing:
- hsync low while H_DISPLAY+H_FP <= h_cnt < H_DISPLAY+H_FP+H_SYNC.
- vsync low over the same window built from the V_ parameters.
REQ-007 FIFO push SHALL be source_vld & ~stall. The pushed entry is {start, r, g, b}; hc and vc are dropped.
REQ-008 stall SHALL be combinational, high when fifo_count >= FIFO_DEPTH-AFULL_MARGIN. The FIFO SHALL never overflow.
REQ-009 The FSM states SHALL be SEEK, ARMED and RUN; SEEK is the reset state.
REQ-010 SEEK:
- Pop one entry per clk while the FIFO is non-empty and the head has start=0.
- If the head has start=1, do not pop; go to ARMED.
REQ-011 ARMED: hold the head. On the tick where h_cnt=0 and v_cnt=0, go to RUN and consume the head at that pixel.
REQ-012 RUN, on each active tick:
- Head present with start=0: pop it and display it.
- FIFO empty: display black, pulse underflow, go to SEEK.
- Head has start=1 at a position other than (0,0): do not pop, display black, pulse underflow, go to SEEK.
REQ-013 RUN at (0,0) with head start=1 SHALL pop and display normally (the next frame is aligned).
REQ-014 On non-active ticks, and in SEEK/ARMED, the display SHALL be black (all zeros). No pop SHALL occur on non-active ticks in RUN.
REQ-015 Outputs SHALL be registered. vga_hsync, vga_vsync and vga_r/g/b SHALL update together, one clk after the tick whose counters they reflect.
REQ-016 A push and a pop in the same cycle SHALL leave fifo_count unchanged. A push into an empty FIFO SHALL be poppable no earlier than the next cycle.
REQ-017 underflow SHALL be exactly one clk wide per event.

Reset
REQ-018 While rst_n=0, state SHALL be as follows:
- Counters 0.
- FIFO empty.
- FSM in SEEK.
- vga_hsync=1, vga_vsync=1.
- RGB=0, underflow=0.
REQ-019 stall SHALL be 0 during reset.
REQ-020 A reset asserted mid-frame SHALL discard all FIFO content immediately. After release, timing restarts at (0,0).

Structure
REQ-021 vga_frame_t, R_SIZE/G_SIZE/B_SIZE/RGB_SIZE and the FSM state enum SHALL come from the shared vga package/header. The timing defaults SHALL be package constants.
REQ-022 The FIFO SHALL be a sub-module vga_sync_fifo:
- Parameters: DW, DEPTH.
- Outputs: count, empty, full, and a show-ahead head.
- Asynchronous active-low reset.

Verification
REQ-023 The bench SHALL cover these directed scenarios, each with H 8/1/2/1, V 4/1/1/1, PIX_DIV=2, FIFO_DEPTH=8, AFULL_MARGIN=2:
- Reset release, no input: vsync low exactly on lines 5..5; hsync low at h=9..10; RGB=0; underflow never pulses.
- Continuous frames, start on pixel 0, r=pixel index: vga_r shows 0..31 in raster order from the first (0,0) after ARMED.
- Upstream always valid: stall rises at count=6, fifo_count never exceeds 8, no pixel lost or duplicated.
- Three garbage pixels (start=0) before a frame: discarded in SEEK; the display begins at the first start=1 entry.
- Input stops after 10 pixels of a frame: underflow pulses once at pixel 10, then black until the next aligned frame.
- rst_n pulsed low mid-line for 3 clk: outputs go to reset values asynchronously, and the FIFO is empty after release.
